// File: rtl/mod_sq_integrator.sv
// Non-coherent integrator: sums cfg_len squared-magnitude samples per frame with
// saturation, threshold detect and optional peak tracking (define MOD_SQ_PEAK_EN).
module mod_sq_integrator #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ACC_W-1:0]  cfg_threshold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat,
  output logic              out_detect,
  output logic [DATA_W-1:0] out_peak,
  output logic [LEN_W-1:0]  out_peak_idx
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  state_t             r_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_sat;

  logic               w_idle;
  logic               w_in_fire;
  logic [ACC_W-1:0]   w_acc_in;
  logic [ACC_W:0]     w_add;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic               w_sat_nxt;
  logic [LEN_W-1:0]   w_cnt_nxt;
  logic [LEN_W-1:0]   w_len_eff;
  logic               w_last;

  // in_ready is held low while reset is asserted so every output reads 0 in reset.
  assign in_ready  = ~reset & (r_state != S_HOLD);
  assign w_in_fire = in_valid & in_ready;
  assign w_idle    = (r_state == S_IDLE);

  // The first sample of a frame starts from a clean accumulator.
  assign w_acc_in  = w_idle ? '0 : r_acc;
  assign w_add     = {1'b0, w_acc_in} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
  assign w_acc_nxt = w_add[ACC_W] ? ACC_MAX : w_add[ACC_W-1:0];
  assign w_sat_nxt = (w_idle ? 1'b0 : r_sat) | w_add[ACC_W];
  assign w_cnt_nxt = w_idle ? LEN_ONE : r_cnt + LEN_ONE;
  assign w_len_eff = w_idle ? ((cfg_len == '0) ? LEN_ONE : cfg_len) : r_len;
  assign w_last    = (w_cnt_nxt == w_len_eff);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_sat      <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_sat    <= 1'b0;
      out_detect <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_in_fire) begin
            r_acc <= w_acc_nxt;
            r_sat <= w_sat_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_idle) r_len <= w_len_eff;
            if (w_last) begin
              r_state    <= S_HOLD;
              out_valid  <= 1'b1;
              out_sum    <= w_acc_nxt;
              out_sat    <= w_sat_nxt;
              out_detect <= (w_acc_nxt > cfg_threshold);
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MOD_SQ_PEAK_EN
  logic [DATA_W-1:0] r_peak;
  logic [LEN_W-1:0]  r_idx;
  logic              w_pk_upd;
  logic [DATA_W-1:0] w_peak_nxt;
  logic [LEN_W-1:0]  w_idx_nxt;

  // Strictly-greater update keeps the earliest index on ties; r_cnt is the new sample's index.
  assign w_pk_upd   = w_idle | (in_data > r_peak);
  assign w_peak_nxt = w_pk_upd ? in_data : r_peak;
  assign w_idx_nxt  = w_idle ? '0 : (w_pk_upd ? r_cnt : r_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_peak       <= '0;
      r_idx        <= '0;
      out_peak     <= '0;
      out_peak_idx <= '0;
    end else if (w_in_fire) begin
      r_peak <= w_peak_nxt;
      r_idx  <= w_idx_nxt;
      if (w_last) begin
        out_peak     <= w_peak_nxt;
        out_peak_idx <= w_idx_nxt;
      end
    end
  end
`else
  assign out_peak     = '0;
  assign out_peak_idx = '0;
`endif

endmodule

// File: tb/tb_mod_sq_integrator.sv
// Scoreboard bench for mod_sq_integrator: default instance plus an ACC_W=16 instance
// for saturation.
module tb_mod_sq_integrator;
  localparam int DW = 16;
  localparam int AW = 24;
  localparam int LW = 8;

  typedef logic [DW-1:0] smp_q_t[$];
  typedef struct {
    logic [AW-1:0] sum;
    logic          sat;
    logic          det;
    logic [DW-1:0] peak;
    logic [LW-1:0] idx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_peak;
  logic [LW-1:0] cfg_len, out_peak_idx;
  logic [AW-1:0] cfg_threshold, out_sum;
  logic          out_sat, out_detect;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_sat, s_out_det;
  logic [DW-1:0] s_in_data, s_thr, s_out_sum, s_out_peak;
  logic [LW-1:0] s_cfg_len, s_out_idx;

  mod_sq_integrator #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_len(cfg_len), .cfg_threshold(cfg_threshold), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_sat(out_sat), .out_detect(out_detect),
    .out_peak(out_peak), .out_peak_idx(out_peak_idx)
  );

  mod_sq_integrator #(.DATA_W(DW), .ACC_W(16), .LEN_W(LW)) dut16 (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .cfg_len(s_cfg_len), .cfg_threshold(s_thr), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_sum(s_out_sum), .out_sat(s_out_sat), .out_detect(s_out_det),
    .out_peak(s_out_peak), .out_peak_idx(s_out_idx)
  );

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Scoreboard monitor: pops one expected frame per output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_frame got sum=%0d", out_sum);
      end else begin
        e = sb.pop_front();
        if (out_sum !== e.sum) begin
          failures++; $display("FAIL sb_sum got=%0d exp=%0d", out_sum, e.sum);
        end
        checks++;
        if (out_sat !== e.sat) begin
          failures++; $display("FAIL sb_sat got=%0b exp=%0b", out_sat, e.sat);
        end
        checks++;
        if (out_detect !== e.det) begin
          failures++; $display("FAIL sb_detect got=%0b exp=%0b", out_detect, e.det);
        end
        checks++;
        if (out_peak !== e.peak || out_peak_idx !== e.idx) begin
          failures++;
          $display("FAIL sb_peak got=%0d@%0d exp=%0d@%0d", out_peak, out_peak_idx, e.peak, e.idx);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic expect_frame(input logic [AW-1:0] thr, input smp_q_t s);
    exp_t e;
    longint total = 0;
    longint maxv = (longint'(1) << AW) - 1;
    logic [DW-1:0] pk = s[0];
    logic [LW-1:0] ix = '0;
    foreach (s[i]) begin
      total += longint'(s[i]);
      if (s[i] > pk) begin pk = s[i]; ix = LW'(i); end
    end
    e.sat = (total > maxv);
    e.sum = e.sat ? AW'(maxv) : AW'(total);
    e.det = (e.sum > thr);
`ifdef MOD_SQ_PEAK_EN
    e.peak = pk; e.idx = ix;
`else
    e.peak = '0; e.idx = '0;
`endif
    sb.push_back(e);
  endtask

  task automatic send_sample(input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout got=%0b exp=1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [LW-1:0] len, input logic [AW-1:0] thr, input smp_q_t s);
    cfg_len = len;
    cfg_threshold = thr;
    expect_frame(thr, s);
    foreach (s[i]) send_sample(s[i]);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0 || out_valid) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d out_valid=%0b exp pending=0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 0; in_data = '0; cfg_len = '0; cfg_threshold = '0; out_ready = 1'b1;
    s_in_valid = 0; s_in_data = '0; s_cfg_len = '0; s_thr = '0; s_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 0 || out_sum !== '0 || out_sat !== 0 || out_detect !== 0 ||
        out_peak !== '0 || out_peak_idx !== '0 || in_ready !== 0) begin
      failures++;
      $display("FAIL reset_outputs got v=%0b sum=%0d sat=%0b det=%0b pk=%0d rdy=%0b exp all 0",
               out_valid, out_sum, out_sat, out_detect, out_peak, in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%0b exp=1", in_ready);
    end
  endtask

  task automatic test_basic();
    smp_q_t q = '{16'd10, 16'd20, 16'd30, 16'd40};
    cfg_len = 8'd4; cfg_threshold = '0;
    expect_frame('0, q);
    for (int i = 0; i < 3; i++) send_sample(q[i]);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_early_valid got=%0b exp=0", out_valid);
    end
    send_sample(q[3]);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 24'd100 || out_sat !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency got v=%0b rdy=%0b sum=%0d sat=%0b exp v=1 rdy=0 sum=100 sat=0",
               out_valid, in_ready, out_sum, out_sat);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    send_frame(8'd3, 24'd50, '{16'd16, 16'd16, 16'd16});
    send_frame(8'd3, 24'd50, '{16'd17, 16'd17, 16'd17});
    drain();
  endtask

  task automatic test_sat();
    s_cfg_len = 8'd2; s_thr = 16'h1000;
    @(negedge clk); s_in_valid = 1'b1; s_in_data = 16'hFFFF;
    @(posedge clk);
    @(negedge clk); s_in_data = 16'h0002;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    checks++;
    if (s_out_valid !== 1'b1 || s_out_sum !== 16'hFFFF || s_out_sat !== 1'b1 || s_out_det !== 1'b1) begin
      failures++;
      $display("FAIL sat16 got v=%0b sum=%h sat=%0b det=%0b exp v=1 sum=ffff sat=1 det=1",
               s_out_valid, s_out_sum, s_out_sat, s_out_det);
    end
    @(posedge clk); #1;
    checks++;
    if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
      failures++; $display("FAIL sat16_release got v=%0b rdy=%0b exp v=0 rdy=1", s_out_valid, s_in_ready);
    end
  endtask

  task automatic test_len0_stall();
    out_ready = 1'b0;
    send_frame(8'd0, 24'd100, '{16'd7});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 24'd7 || in_ready !== 1'b0 || out_detect !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got v=%0b sum=%0d rdy=%0b det=%0b exp v=1 sum=7 rdy=0 det=0",
                 c, out_valid, out_sum, in_ready, out_detect);
      end
    end
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_peak();
    logic [DW-1:0] ep;
    logic [LW-1:0] ei;
`ifdef MOD_SQ_PEAK_EN
    ep = 16'd9; ei = 8'd1;
`else
    ep = '0; ei = '0;
`endif
    out_ready = 1'b0;
    send_frame(8'd5, 24'd0, '{16'd3, 16'd9, 16'd2, 16'd9, 16'd1});
    checks++;
    if (out_peak !== ep || out_peak_idx !== ei || out_sum !== 24'd24) begin
      failures++;
      $display("FAIL peak got=%0d@%0d sum=%0d exp=%0d@%0d sum=24", out_peak, out_peak_idx, out_sum, ep, ei);
    end
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_abort();
    cfg_len = 8'd4; cfg_threshold = 24'd19;
    send_sample(16'd100);
    send_sample(16'd200);
    in_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL abort_in_reset got v=%0b rdy=%0b exp 0 0", out_valid, in_ready);
    end
    @(negedge clk); reset = 1'b0;
    send_frame(8'd4, 24'd19, '{16'd5, 16'd5, 16'd5, 16'd5});
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 24'd20 || out_detect !== 1'b1) begin
      failures++;
      $display("FAIL abort_sum got v=%0b sum=%0d det=%0b exp v=1 sum=20 det=1", out_valid, out_sum, out_detect);
    end
    drain();
  endtask

  task automatic test_big_frame();
    smp_q_t q;
    for (int i = 0; i < 255; i++) q.push_back(DW'($urandom_range(60000, 65535)));
    send_frame(8'd255, 24'd16000000, q);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_sat();
    test_len0_stall();
    test_peak();
    test_reset_abort();
    test_big_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
